bcd3_seg7_scan: RTL and testbench
=================================

// Module: bcd3_seg7_scan
// PURPOSE
//  Time-multiplexed 3-digit 7-segment driver. It consumes the hundreds/tens/ones BCD
//  digits produced by the 8-bit hex-to-decimal converter and scans them onto a shared
//  segment bus with per-digit enables. New digits pass through a valid/ready handshake.
//  They are double-buffered and swapped only at frame boundaries, so the display never tears.
// PARAMETERS
//  SCAN_DIV   50000  clock cycles per digit slot (>= GUARD+2)
//  GUARD      16     cycles at the start of each slot with all anodes off (anti-ghosting)
//  ACTIVE_LOW 1      1: seg/an outputs active-low; 0: active-high
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   digit triplet valid
//  in_ready   out  1   block can accept a triplet (no update pending)
//  hundreds   in   4   BCD hundreds digit
//  tens       in   4   BCD tens digit
//  ones       in   4   BCD ones digit
//  seg        out  7   segments {g,f,e,d,c,b,a}
//  an         out  3   digit enables {hundreds,tens,ones}
//  frame_tick out  1   1-cycle pulse when the shadow-to-active swap point is reached
// BEHAVIOUR
//  - Reset (async, active-high):
//    - div_cnt=0, idx=0 (ones), active and shadow digits = 0, pending=0, in_ready=1.
//    - seg and an all off (all 1s if ACTIVE_LOW), frame_tick=0.
//  - Counters:
//    - div_cnt counts 0..SCAN_DIV-1 and wraps.
//    - On wrap, idx advances 0->1->2->0 (0=ones, 1=tens, 2=hundreds).
//  - Frame boundary: cycle with div_cnt==SCAN_DIV-1 && idx==2.
//    - frame_tick is registered and is high on the following cycle.
//  - Handshake:
//    - Capture happens on in_valid && in_ready: digits go into shadow, pending=1, in_ready=0 next cycle.
//    - At a frame boundary with pending=1: shadow->active, pending=0, in_ready=1 next cycle.
//    - Capture and swap in the same cycle cannot occur, because in_ready=0 while pending.
//    - A capture on a boundary cycle with pending=0 is swapped at the NEXT boundary, not the current one.
//    - in_valid while in_ready=0 is ignored; the producer must hold it.
//  - Slot output (registered; 1-cycle latency from div_cnt/idx):
//    - When div_cnt < GUARD: an all off, seg all off.
//    - Otherwise: an enables only digit idx; seg = decode(active[idx]).
//  - Decode:
//    - Standard 0-9.
//    - Values 10-15 show a dash (segment g only).
//    - Blanked digits: segments off, anode still enabled.
//  - Leading-zero blanking (evaluated on active digits):
//    - hundreds is blanked if ==0.
//    - tens is blanked if hundreds==0 && tens==0.
//    - ones is never blanked.
//  - Polarity: ACTIVE_LOW inverts both seg and an at the output register only.
//  - Reset mid-frame: everything returns to reset values immediately.
//    - A pending shadow triplet is discarded.
// TESTING (SCAN_DIV=8, GUARD=2, ACTIVE_LOW=0 unless noted)
//  1. Release reset, no input:
//     - one frame shows ones slot an=001, seg=0111111 ("0") after the guard;
//     - tens and hundreds slots have their anode on and seg=0000000.
//  2. Load 2/5/5 mid-frame:
//     - in_ready drops the next cycle;
//     - display keeps the old value until frame_tick;
//     - after the swap, an=100 shows seg=1011011 ("2") and in_ready=1.
//  3. Load 0/0/7:
//     - hundreds and tens slots are blank;
//     - ones slot shows seg=0000111.
//  4. Load 0/4/0:
//     - hundreds is blank, tens shows 1100110, ones shows 0111111.
//     - Load 1/12/3 -> tens slot shows a dash (seg=1000000).
//  5. Hold in_valid with a second triplet while pending:
//     - not accepted until in_ready=1;
//     - accepted the cycle after the swap and shown one frame later.
//     - Also assert in_valid on a boundary cycle with pending=0 -> swap is deferred to the next boundary.
//  6. Assert rst mid-slot while pending:
//     - seg/an go off asynchronously and in_ready=1;
//     - after release, the display shows "  0".
//     - ACTIVE_LOW=1 rerun -> seg/an are the bitwise inverse of the above.

Source files
------------

// File: rtl/bcd3_seg7_scan.sv
// bcd3_seg7_scan: time-multiplexed 3-digit 7-segment driver with a
// valid/ready digit input, shadow/active double buffering swapped at frame
// boundaries, leading-zero blanking and an anti-ghosting guard at slot start.
module bcd3_seg7_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned GUARD      = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  localparam logic [1:0] IDX_ONES     = 2'd0;
  localparam logic [1:0] IDX_TENS     = 2'd1;
  localparam logic [1:0] IDX_HUNDREDS = 2'd2;

  // Idle levels of the physical pins
  localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [AN_W-1:0]  AN_OFF  = ACTIVE_LOW ? {AN_W{1'b1}}  : {AN_W{1'b0}};

  // Scan position
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;

  // Shadow (freshly captured) and active (being displayed) digit sets
  logic [3:0] sh_h, sh_t, sh_o;
  logic [3:0] act_h, act_t, act_o;
  logic       pending;

  // Combinational helpers
  logic             slot_wrap_c;
  logic             frame_boundary_c;
  logic             capture_c;
  logic             swap_c;
  logic [3:0]       slot_digit_c;
  logic             slot_blank_c;
  logic [SEG_W-1:0] slot_glyph_c;
  logic [SEG_W-1:0] seg_nxt_c;
  logic [AN_W-1:0]  an_nxt_c;

  // Frame boundary and handshake qualifiers
  always_comb begin
    slot_wrap_c      = (div_cnt == CNT_LAST);
    frame_boundary_c = slot_wrap_c && (idx == IDX_HUNDREDS);
    capture_c        = in_valid && in_ready;
    swap_c           = frame_boundary_c && pending;
  end

  // Divider and digit-slot index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= IDX_ONES;
    end else if (slot_wrap_c) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_HUNDREDS) ? IDX_ONES : idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Capture into shadow, promote to active only at a frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_h     <= 4'd0;
      sh_t     <= 4'd0;
      sh_o     <= 4'd0;
      act_h    <= 4'd0;
      act_t    <= 4'd0;
      act_o    <= 4'd0;
      pending  <= 1'b0;
      in_ready <= 1'b1;
    end else if (swap_c) begin
      act_h    <= sh_h;
      act_t    <= sh_t;
      act_o    <= sh_o;
      pending  <= 1'b0;
      in_ready <= 1'b1;
    end else if (capture_c) begin
      // A capture on a boundary with nothing pending lands here, so its
      // swap naturally waits for the following boundary.
      sh_h     <= hundreds;
      sh_t     <= tens;
      sh_o     <= ones;
      pending  <= 1'b1;
      in_ready <= 1'b0;
    end
  end

  // Frame tick is the registered boundary flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_boundary_c;
    end
  end

  // Select the active digit for this slot and apply leading-zero blanking
  always_comb begin
    slot_digit_c = act_o;
    slot_blank_c = 1'b0;
    case (idx)
      IDX_TENS: begin
        slot_digit_c = act_t;
        slot_blank_c = (act_h == 4'd0) && (act_t == 4'd0);
      end
      IDX_HUNDREDS: begin
        slot_digit_c = act_h;
        slot_blank_c = (act_h == 4'd0);
      end
      default: begin
        slot_digit_c = act_o;
        slot_blank_c = 1'b0;
      end
    endcase
  end

  // BCD to segments {g,f,e,d,c,b,a}, non-decimal codes show a dash
  always_comb begin
    slot_glyph_c = 7'b1000000;
    case (slot_digit_c)
      4'd0:    slot_glyph_c = 7'b0111111;
      4'd1:    slot_glyph_c = 7'b0000110;
      4'd2:    slot_glyph_c = 7'b1011011;
      4'd3:    slot_glyph_c = 7'b1001111;
      4'd4:    slot_glyph_c = 7'b1100110;
      4'd5:    slot_glyph_c = 7'b1101101;
      4'd6:    slot_glyph_c = 7'b1111101;
      4'd7:    slot_glyph_c = 7'b0000111;
      4'd8:    slot_glyph_c = 7'b1111111;
      4'd9:    slot_glyph_c = 7'b1101111;
      default: slot_glyph_c = 7'b1000000;
    endcase
  end

  // Slot drive in active-high sense: dark during the guard window
  always_comb begin
    seg_nxt_c = '0;
    an_nxt_c  = '0;
    if (div_cnt >= CNT_GUARD) begin
      seg_nxt_c = slot_blank_c ? 7'b0000000 : slot_glyph_c;
      case (idx)
        IDX_TENS:     an_nxt_c = 3'b010;
        IDX_HUNDREDS: an_nxt_c = 3'b100;
        default:      an_nxt_c = 3'b001;
      endcase
    end
  end

  // Output register; polarity is applied only here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else if (ACTIVE_LOW) begin
      seg <= ~seg_nxt_c;
      an  <= ~an_nxt_c;
    end else begin
      seg <= seg_nxt_c;
      an  <= an_nxt_c;
    end
  end

endmodule

// File: tb/tb_bcd3_seg7_scan.sv
// Directed bench for bcd3_seg7_scan: two instances share stimulus, one
// active-high and one active-low, the latter always expected as the inverse.
module tb_bcd3_seg7_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] hundreds = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;

  logic       ready_h, ready_l;
  logic [6:0] seg_h, seg_l;
  logic [2:0] an_h, an_l;
  logic       tick_h, tick_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd3_seg7_scan #(.SCAN_DIV(8), .GUARD(2), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_h),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .seg(seg_h), .an(an_h), .frame_tick(tick_h)
  );

  bcd3_seg7_scan #(.SCAN_DIV(8), .GUARD(2), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_l),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .seg(seg_l), .an(an_l), .frame_tick(tick_l)
  );

  always #5 clk = ~clk;

  // Advance to n clock edges after the last reset release, sampling #1 later
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_disp(input string tag, input logic [2:0] an_e, input logic [6:0] seg_e);
    checks++;
    assert (an_h === an_e) else begin
      errors++;
      $error("FAIL %s an: observed %b expected %b", tag, an_h, an_e);
    end
    checks++;
    assert (seg_h === seg_e) else begin
      errors++;
      $error("FAIL %s seg: observed %b expected %b", tag, seg_h, seg_e);
    end
    checks++;
    assert (an_l === ~an_e) else begin
      errors++;
      $error("FAIL %s an_low: observed %b expected %b", tag, an_l, ~an_e);
    end
    checks++;
    assert (seg_l === ~seg_e) else begin
      errors++;
      $error("FAIL %s seg_low: observed %b expected %b", tag, seg_l, ~seg_e);
    end
  endtask

  task automatic chk_ready(input string tag, input logic e);
    checks++;
    assert (ready_h === e && ready_l === e) else begin
      errors++;
      $error("FAIL %s in_ready: observed %b/%b expected %b", tag, ready_h, ready_l, e);
    end
  endtask

  task automatic chk_tick(input string tag, input logic e);
    checks++;
    assert (tick_h === e && tick_l === e) else begin
      errors++;
      $error("FAIL %s frame_tick: observed %b/%b expected %b", tag, tick_h, tick_l, e);
    end
  endtask

  task automatic drive(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    hundreds = h;
    tens     = t;
    ones     = o;
    in_valid = 1'b1;
  endtask

  initial begin
    // Reset state
    #3 rst = 1'b1;
    #1;
    chk_disp("reset", 3'b000, 7'b0000000);
    chk_ready("reset", 1'b1);
    chk_tick("reset", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // 1: idle frame shows "  0"
    goto(1);  chk_disp("t1_guard", 3'b000, 7'b0000000);
    goto(4);  chk_disp("t1_ones", 3'b001, 7'b0111111);
    goto(12); chk_disp("t1_tens", 3'b010, 7'b0000000);
    goto(20); chk_disp("t1_hund", 3'b100, 7'b0000000);
    chk_ready("t1", 1'b1);

    // 2: load 2/5/5 mid-frame, swapped at the frame boundary
    drive(4'd2, 4'd5, 4'd5);
    goto(21); chk_ready("t2_drop", 1'b0);
    in_valid = 1'b0;
    goto(23); chk_disp("t2_old", 3'b100, 7'b0000000);
    chk_tick("t2_pre", 1'b0);
    goto(24); chk_tick("t2_tick", 1'b1);
    chk_ready("t2_swap", 1'b1);
    goto(25); chk_tick("t2_post", 1'b0);
    goto(28); chk_disp("t2_ones", 3'b001, 7'b1101101);
    goto(36); chk_disp("t2_tens", 3'b010, 7'b1101101);
    goto(44); chk_disp("t2_hund", 3'b100, 7'b1011011);

    // 3: 0/0/7 blanks both leading digits
    drive(4'd0, 4'd0, 4'd7);
    goto(45); in_valid = 1'b0;
    goto(52); chk_disp("t3_ones", 3'b001, 7'b0000111);
    goto(60); chk_disp("t3_tens", 3'b010, 7'b0000000);
    goto(68); chk_disp("t3_hund", 3'b100, 7'b0000000);

    // 4: 0/4/0 then 1/12/3 (dash)
    drive(4'd0, 4'd4, 4'd0);
    goto(69); in_valid = 1'b0;
    goto(76); chk_disp("t4a_ones", 3'b001, 7'b0111111);
    goto(84); chk_disp("t4a_tens", 3'b010, 7'b1100110);
    goto(92); chk_disp("t4a_hund", 3'b100, 7'b0000000);
    drive(4'd1, 4'd12, 4'd3);
    goto(93); in_valid = 1'b0;
    goto(100); chk_disp("t4b_ones", 3'b001, 7'b1001111);
    goto(108); chk_disp("t4b_tens", 3'b010, 7'b1000000);
    goto(116); chk_disp("t4b_hund", 3'b100, 7'b0000110);

    // 5: second triplet held while pending
    drive(4'd9, 4'd8, 4'd7);
    goto(117); chk_ready("t5_a_taken", 1'b0);
    drive(4'd4, 4'd3, 4'd2);
    goto(119); chk_ready("t5_b_held", 1'b0);
    goto(120); chk_ready("t5_swap", 1'b1);
    chk_tick("t5_tick", 1'b1);
    goto(121); chk_ready("t5_b_taken", 1'b0);
    in_valid = 1'b0;
    goto(124); chk_disp("t5a_ones", 3'b001, 7'b0000111);
    goto(132); chk_disp("t5a_tens", 3'b010, 7'b1111111);
    goto(140); chk_disp("t5a_hund", 3'b100, 7'b1101111);
    goto(148); chk_disp("t5b_ones", 3'b001, 7'b1011011);
    goto(156); chk_disp("t5b_tens", 3'b010, 7'b1001111);
    goto(164); chk_disp("t5b_hund", 3'b100, 7'b1100110);

    // 5b: capture on a boundary cycle is deferred one frame
    goto(167);
    drive(4'd5, 4'd0, 4'd1);
    goto(168); chk_tick("t5c_tick", 1'b1);
    chk_ready("t5c_taken", 1'b0);
    in_valid = 1'b0;
    goto(172); chk_disp("t5c_still_old", 3'b001, 7'b1011011);
    goto(191); chk_ready("t5c_wait", 1'b0);
    goto(192); chk_ready("t5c_swap", 1'b1);
    goto(196); chk_disp("t5c_ones", 3'b001, 7'b0000110);
    goto(204); chk_disp("t5c_tens", 3'b010, 7'b0111111);
    goto(212); chk_disp("t5c_hund", 3'b100, 7'b1101101);

    // 6: async reset mid-slot with a triplet pending
    drive(4'd8, 4'd8, 4'd8);
    goto(213); chk_ready("t6_pending", 1'b0);
    in_valid = 1'b0;
    goto(214);
    #2 rst = 1'b1;
    #1;
    chk_disp("t6_async", 3'b000, 7'b0000000);
    chk_ready("t6_async", 1'b1);
    chk_tick("t6_async", 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    goto(4);  chk_disp("t6_ones", 3'b001, 7'b0111111);
    goto(12); chk_disp("t6_tens", 3'b010, 7'b0000000);
    goto(20); chk_disp("t6_hund", 3'b100, 7'b0000000);
    goto(24); chk_tick("t6_tick", 1'b1);
    chk_ready("t6_nothing_pending", 1'b1);
    goto(28); chk_disp("t6_discarded", 3'b001, 7'b0111111);
    goto(36); chk_disp("t6_tens2", 3'b010, 7'b0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
